// File: rtl/spi_slave_rw_regbank.sv
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_rw_regbank                                         |
// | Description : SPI mode-0 responder, 16-bit frames, 16 x 8 register bank    |
// |               with MISO readback and a local host port. Optional macro     |
// |               SPI_FRAME_ERR_EN adds sticky frame_err and err_cnt outputs.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_slave_rw_regbank #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       miso_oe,
    input  logic       loc_we,
    input  logic [3:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_done,
    output logic       rd_done,
    output logic [3:0] last_addr,
    output logic [7:0] last_data
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic       frame_err,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_hdr    = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_commit = 3'd3;
    localparam logic [2:0] c_st_wait   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;

    logic [2:0] r_state;
    logic [3:0] r_bit_cnt;
    logic       r_sclk_prev;
    logic       r_armed;
    logic [6:0] r_rx;
    logic [6:0] r_tx;
    logic [7:0] r_tx_val;
    logic [3:0] r_addr;
    logic       r_rnw;
    logic [7:0] r_data;
    logic       r_miso;
    logic       r_miso_oe;
    logic       r_wr_done;
    logic       r_rd_done;
    logic [3:0] r_last_addr;
    logic [7:0] r_last_data;
    logic [7:0] r_regs [NUM_REGS];

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;
    logic w_rise;
    logic w_fall;
    logic w_abort;

    // Synchronizers keep tracking the pins through reset so cs is never stale.
    always_ff @(posedge clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_prev;
    assign w_fall   = ~w_sclk_s & r_sclk_prev;
    assign w_abort  = w_cs_s & ((r_state == c_st_hdr) | (r_state == c_st_data));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= 4'd0;
            r_sclk_prev <= 1'b0;
            r_armed     <= 1'b0;
            r_rx        <= 7'd0;
            r_tx        <= 7'd0;
            r_tx_val    <= 8'd0;
            r_addr      <= 4'd0;
            r_rnw       <= 1'b0;
            r_data      <= 8'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_last_addr <= 4'd0;
            r_last_data <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'd0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_miso_oe   <= ~w_cs_s;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            // A frame may only start after cs has been seen high since reset.
            if (w_cs_s) r_armed <= 1'b1;
            if (loc_we) r_regs[loc_addr] <= loc_wdata;

            case (r_state)
                c_st_idle: begin
                    r_bit_cnt <= 4'd0;
                    r_miso    <= 1'b0;
                    if (r_armed && !w_cs_s) r_state <= c_st_hdr;
                end
                c_st_hdr: begin
                    if (w_cs_s) begin
                        r_state   <= c_st_idle;
                        r_bit_cnt <= 4'd0;
                        r_miso    <= 1'b0;
                    end else if (w_rise) begin
                        r_rx      <= {r_rx[5:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_addr  <= r_rx[6:3];
                            r_rnw   <= r_rx[2];
                            r_state <= c_st_data;
                            if (r_rx[2]) begin
                                r_tx     <= r_regs[r_rx[6:3]][6:0];
                                r_tx_val <= r_regs[r_rx[6:3]];
                                r_miso   <= r_regs[r_rx[6:3]][7];
                            end
                        end
                    end
                end
                c_st_data: begin
                    if (w_cs_s) begin
                        r_state   <= c_st_idle;
                        r_bit_cnt <= 4'd0;
                        r_miso    <= 1'b0;
                    end else begin
                        if (w_rise) begin
                            r_rx      <= {r_rx[5:0], w_mosi_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd15) begin
                                r_data  <= {r_rx, w_mosi_s};
                                r_state <= c_st_commit;
                            end
                        end
                        // Bit 7 is already on the wire; the falling edge right after the header keeps it.
                        if (w_fall && r_rnw && (r_bit_cnt != 4'd8)) begin
                            r_tx   <= {r_tx[5:0], 1'b0};
                            r_miso <= r_tx[6];
                        end
                    end
                end
                c_st_commit: begin
                    r_miso      <= 1'b0;
                    r_last_addr <= r_addr;
                    if (r_rnw) begin
                        r_rd_done   <= 1'b1;
                        r_last_data <= r_tx_val;
                    end else begin
                        r_regs[r_addr] <= r_data;
                        r_wr_done      <= 1'b1;
                        r_last_data    <= r_data;
                    end
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    r_bit_cnt <= 4'd0;
                    if (w_cs_s) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic       r_frame_err;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else if (loc_we && (loc_addr == 4'hF)) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else if (w_abort) begin
            r_frame_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

    assign miso      = r_miso & r_miso_oe;
    assign miso_oe   = r_miso_oe;
    assign wr_done   = r_wr_done;
    assign rd_done   = r_rd_done;
    assign last_addr = r_last_addr;
    assign last_data = r_last_data;
    assign loc_rdata = r_regs[loc_addr];

endmodule

`default_nettype wire
